segre_icache_tag_sa: RTL
========================

# segre_icache_tag_sa

Parametrised set-associative tag store for the Segre instruction cache. It replaces the fully-associative lane tag array and holds valid bits, tags and true-LRU age state per set. It provides registered lookup, fill with victim selection and eviction report, single-line invalidation, and a multi-cycle full-flush sweep. It sits between the fetch-side cache controller and the icache data array, and supplies the way index the data array uses.

## Interface
- NUM_WAYS, 4, associativity; power of two, ≥2; WAY_W = $clog2(NUM_WAYS)
- NUM_SETS, 8, number of sets; power of two, ≥2; SET_W = $clog2(NUM_SETS)
- TAG_SIZE, ICACHE_TAG_SIZE, tag width in bits
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- req_i  in  1  lookup request
- index_i  in  SET_W  lookup set
- tag_i  in  TAG_SIZE  lookup tag
- hit_o  out  1  registered lookup hit pulse
- miss_o  out  1  registered lookup miss pulse
- hit_way_o  out  WAY_W  hitting way; 0 on miss
- fill_i  in  1  install fill_tag_i into set fill_index_i
- fill_index_i  in  SET_W  fill set
- fill_tag_i  in  TAG_SIZE  fill tag
- fill_done_o  out  1  registered fill-complete pulse
- fill_way_o  out  WAY_W  way written by the last fill
- evict_valid_o  out  1  the overwritten way held a valid line
- evict_tag_o  out  TAG_SIZE  tag of the overwritten line
- inv_i  in  1  invalidate a single line
- inv_index_i  in  SET_W  invalidate set
- inv_tag_i  in  TAG_SIZE  invalidate tag
- flush_i  in  1  invalidate all sets
- busy_o  out  1  flush sweep in progress
- ready_o  out  1  equals !busy_o

## Operation
- Per-set state:
  - valid[NUM_WAYS]
  - tag[NUM_WAYS]
  - age[NUM_WAYS] (WAY_W bits each), forming a permutation of 0..NUM_WAYS-1 at all times
  - age 0 is MRU; age NUM_WAYS-1 is LRU
- Reset:
  - All valid bits are 0, all tags are 0.
  - age[w] = w in every set.
  - FSM is IDLE. All outputs are 0 except ready_o = 1.
- Lookup:
  - Hit means valid[w] && tag[w] == tag_i in set index_i.
  - If several ways match (not possible by construction), the lowest index is reported.
  - Hit touches LRU for way w: age[w] becomes 0, and each way with age < old age[w] increments by 1.
  - Miss leaves all state unchanged.
- Fill victim selection:
  - Victim is the lowest-index invalid way.
  - If no way is invalid, the victim is the way with age NUM_WAYS-1.
  - Victim gets valid=1 and tag=fill_tag_i, then is touched as MRU.
  - evict_valid_o and evict_tag_o report the victim's old contents.
- Fill hitting an existing tag: if fill_tag_i already matches a valid way, that way is rewritten and touched, and evict_valid_o = 0 (no duplicate lines).
- inv: the matching valid way in inv_index_i is cleared. Age state is unchanged. No match is a no-op.
- FSM:
  - IDLE→FLUSH on flush_i. Sweep counter starts at 0.
  - In FLUSH, each cycle clears valid in set `cnt` and resets its ages to the way index, then cnt++.
  - Leaves to IDLE after the cycle that clears set NUM_SETS-1.
- While busy_o:
  - req_i, fill_i, inv_i and flush_i are ignored.
  - No hit_o, miss_o or fill_done_o pulses are produced.
- Same-cycle events in IDLE:
  - flush_i has priority; all other same-cycle requests are dropped.
  - Lookup always sees pre-edge state.
  - Hit and fill to the same set: only the fill's LRU touch is applied.
  - inv and fill to the same set: victim selection uses pre-edge state. Invalidation applies to any matching way except the fill way.
- Width rules: age increments never overflow, because only ages below the touched age increment.

## Timing
- Lookup latency is 1:
  - req_i sampled at edge t.
  - hit_o/miss_o/hit_way_o are valid for exactly the cycle after edge t.
  - LRU update commits at edge t.
- Fill latency is 1: the array is written at edge t; fill_done_o, fill_way_o and evict_* are valid in the following cycle.
- inv commits at the sampling edge; the next-cycle lookup sees it.
- Flush:
  - flush_i sampled at edge t; busy_o is high from t+1 for exactly NUM_SETS cycles.
  - The first request is accepted at edge t+NUM_SETS+1.
- fill_way_o and evict_tag_o hold their values until the next fill. All pulse outputs are single-cycle.
- Asynchronous rst_i assertion mid-flush or mid-fill returns immediately to the reset state. In-flight pulses are cleared.

## Test plan
- Reset, then lookup set 3 tag 0x1A → miss_o=1, hit_way_o=0 next cycle. Fill set 3 tag 0x1A → fill_way_o=0, evict_valid_o=0. Re-lookup → hit_o=1, hit_way_o=0.
- Fill set 2 with tags A, B, C, D (ways 0-3). Hit A. Fill E → victim way 1 (B is LRU), evict_valid_o=1, evict_tag_o=B.
- Fill set 5 tag 0x7, then inv set 5 tag 0x7 → lookup misses. Next fill reuses way 0 with evict_valid_o=0.
- Fill lines in several sets, then pulse flush_i → busy_o high for 8 cycles and ready_o low. req_i during the sweep → no pulses. After the sweep all lookups miss.
- Same cycle: lookup set 1 tag X (not present) plus fill set 1 tag X → miss_o=1. A lookup next cycle hits.
- Assert rst_i asynchronously at sweep cycle 3 → busy_o drops without waiting for a clock edge. After release, ready_o=1 and all lookups miss.

Source files
------------

// File: rtl/segre_icache_tag_sa.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : segre_icache_tag_sa
// Brief    : Set-associative icache tag store with true-LRU ages, fill/victim,
//            single-line invalidate and a one-set-per-cycle flush sweep.
// Revision : 1.0 - initial release
// ============================================================================
module segre_icache_tag_sa #(
   parameter  int NUM_WAYS = 4,
   parameter  int NUM_SETS = 8,
   parameter  int TAG_SIZE = 20,
   localparam int WAY_W    = $clog2(NUM_WAYS),
   localparam int SET_W    = $clog2(NUM_SETS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic [SET_W-1:0]    index_i,
   input  logic [TAG_SIZE-1:0] tag_i,
   output logic                hit_o,
   output logic                miss_o,
   output logic [WAY_W-1:0]    hit_way_o,
   input  logic                fill_i,
   input  logic [SET_W-1:0]    fill_index_i,
   input  logic [TAG_SIZE-1:0] fill_tag_i,
   output logic                fill_done_o,
   output logic [WAY_W-1:0]    fill_way_o,
   output logic                evict_valid_o,
   output logic [TAG_SIZE-1:0] evict_tag_o,
   input  logic                inv_i,
   input  logic [SET_W-1:0]    inv_index_i,
   input  logic [TAG_SIZE-1:0] inv_tag_i,
   input  logic                flush_i,
   output logic                busy_o,
   output logic                ready_o
);

   typedef logic [NUM_WAYS-1:0][WAY_W-1:0] age_vec_t;
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

   localparam logic [WAY_W-1:0] c_lru_age  = WAY_W'(NUM_WAYS - 1);
   localparam logic [SET_W-1:0] c_last_set = SET_W'(NUM_SETS - 1);

   state_t              r_state;
   logic [SET_W-1:0]    r_cnt;
   logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
   logic [TAG_SIZE-1:0] r_tag   [NUM_SETS][NUM_WAYS];
   age_vec_t            r_age   [NUM_SETS];

   logic                w_lk_hit, w_fl_match, w_fl_free, w_inv_hit;
   logic [WAY_W-1:0]    w_lk_way, w_fl_match_way, w_fl_free_way, w_fl_lru_way;
   logic [WAY_W-1:0]    w_fl_way, w_inv_way;
   logic                w_inv_apply;

   // Touched way becomes MRU; only younger ways age, so the permutation holds.
   function automatic age_vec_t touch(input age_vec_t a, input logic [WAY_W-1:0] w);
      age_vec_t n;
      n = a;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (a[i] < a[w]) n[i] = a[i] + 1'b1;
      end
      n[w] = '0;
      return n;
   endfunction

   function automatic age_vec_t age_init();
      age_vec_t n;
      for (int i = 0; i < NUM_WAYS; i++) n[i] = WAY_W'(i);
      return n;
   endfunction

   // Descending scans so the lowest matching index wins.
   always_comb begin
      w_lk_hit       = 1'b0;
      w_lk_way       = '0;
      w_fl_match     = 1'b0;
      w_fl_match_way = '0;
      w_fl_free      = 1'b0;
      w_fl_free_way  = '0;
      w_fl_lru_way   = '0;
      w_inv_hit      = 1'b0;
      w_inv_way      = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (r_valid[index_i][i] && (r_tag[index_i][i] == tag_i)) begin
            w_lk_hit = 1'b1;
            w_lk_way = WAY_W'(i);
         end
         if (r_valid[fill_index_i][i] && (r_tag[fill_index_i][i] == fill_tag_i)) begin
            w_fl_match     = 1'b1;
            w_fl_match_way = WAY_W'(i);
         end
         if (!r_valid[fill_index_i][i]) begin
            w_fl_free     = 1'b1;
            w_fl_free_way = WAY_W'(i);
         end
         if (r_age[fill_index_i][i] == c_lru_age) w_fl_lru_way = WAY_W'(i);
         if (r_valid[inv_index_i][i] && (r_tag[inv_index_i][i] == inv_tag_i)) begin
            w_inv_hit = 1'b1;
            w_inv_way = WAY_W'(i);
         end
      end
      w_fl_way    = w_fl_match ? w_fl_match_way : (w_fl_free ? w_fl_free_way : w_fl_lru_way);
      w_inv_apply = w_inv_hit &&
                    !(fill_i && (inv_index_i == fill_index_i) && (w_inv_way == w_fl_way));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         hit_o         <= 1'b0;
         miss_o        <= 1'b0;
         hit_way_o     <= '0;
         fill_done_o   <= 1'b0;
         fill_way_o    <= '0;
         evict_valid_o <= 1'b0;
         evict_tag_o   <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            r_valid[s] <= '0;
            r_age[s]   <= age_init();
            for (int w = 0; w < NUM_WAYS; w++) r_tag[s][w] <= '0;
         end
      end else begin
         hit_o       <= 1'b0;
         miss_o      <= 1'b0;
         hit_way_o   <= '0;
         fill_done_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (flush_i) begin
                  r_state <= S_FLUSH;
                  r_cnt   <= '0;
               end else begin
                  if (req_i) begin
                     hit_o     <= w_lk_hit;
                     miss_o    <= !w_lk_hit;
                     hit_way_o <= w_lk_way;
                     // A same-set fill owns the LRU update this cycle.
                     if (w_lk_hit && !(fill_i && (fill_index_i == index_i)))
                        r_age[index_i] <= touch(r_age[index_i], w_lk_way);
                  end
                  if (fill_i) begin
                     r_valid[fill_index_i][w_fl_way] <= 1'b1;
                     r_tag[fill_index_i][w_fl_way]   <= fill_tag_i;
                     r_age[fill_index_i]             <= touch(r_age[fill_index_i], w_fl_way);
                     fill_done_o                     <= 1'b1;
                     fill_way_o                      <= w_fl_way;
                     evict_valid_o                   <= !w_fl_match && r_valid[fill_index_i][w_fl_way];
                     evict_tag_o                     <= r_tag[fill_index_i][w_fl_way];
                  end
                  if (inv_i && w_inv_apply)
                     r_valid[inv_index_i][w_inv_way] <= 1'b0;
               end
            end
            S_FLUSH: begin
               r_valid[r_cnt] <= '0;
               r_age[r_cnt]   <= age_init();
               r_cnt          <= r_cnt + 1'b1;
               if (r_cnt == c_last_set) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o  = (r_state == S_FLUSH);
   assign ready_o = !busy_o;

endmodule
`default_nettype wire
